// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP word and PC helpers.
// Reused by the IF/ID and ID stages.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake, pipeline control and IF/ID outputs.
interface if_fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] PCp4_o;
    logic [31:0] Instr_o;
    logic        valid_o;

    modport master (
        output imem_req_o, imem_addr_o, PCp4_o, Instr_o, valid_o,
        input  imem_ready_i, imem_rdata_i, stall_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, PCp4_o, Instr_o, valid_o,
        output imem_ready_i, imem_rdata_i, stall_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/if_fetch_unit_skid_buf.sv
// One-entry skid buffer parking a fetched word and its PC+4 while decode stalls.
module if_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pcp4,
    output logic [31:0] data,
    output logic [31:0] pcp4,
    output logic        valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= NOP_WORD;
            pcp4  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pcp4  <= load_pcp4;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC sequencing, memory handshake, stall skid and redirect flush.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    if_fetch_unit_if.master bus
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc_q;
    logic [31:0]  drop_addr_q;
    logic [31:0]  pc_plus4;

    logic redir, deliver_mem, park, unpark, bubble, advance, capture_drop;

    logic [31:0] skid_data, skid_pcp4;
    logic        skid_valid;

    assign pc_plus4 = pc_q + PC_STEP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_START;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_START: state_nxt = S_REQ;
            S_REQ: begin
                if (bus.redirect_i)
                    state_nxt = bus.imem_ready_i ? S_REQ : S_DROP;
                else if (bus.imem_ready_i && bus.stall_i)
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (bus.redirect_i || !bus.stall_i)
                    state_nxt = S_REQ;
            end
            S_DROP: begin
                if (bus.imem_ready_i)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_START;
        endcase
    end

    // The address of a request being dropped is held so the bus stays stable
    // until memory answers, even though pc_q already points at the target.
    always_comb begin
        bus.imem_req_o  = (state == S_REQ) || (state == S_DROP);
        bus.imem_addr_o = (state == S_DROP) ? drop_addr_q : word_align(pc_q);
        redir        = bus.redirect_i && (state != S_START);
        deliver_mem  = (state == S_REQ) && !redir && bus.imem_ready_i && !bus.stall_i;
        park         = (state == S_REQ) && !redir && bus.imem_ready_i && bus.stall_i;
        unpark       = (state == S_HOLD) && !redir && !bus.stall_i;
        bubble       = (state == S_REQ) && !redir && !bus.imem_ready_i && !bus.stall_i;
        advance      = deliver_mem || park;
        capture_drop = redir && (state == S_REQ) && !bus.imem_ready_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= word_align(RESET_PC);
            drop_addr_q <= '0;
            bus.PCp4_o  <= '0;
            bus.Instr_o <= NOP_WORD;
            bus.valid_o <= 1'b0;
        end else begin
            if (redir)        pc_q <= word_align(bus.redirect_pc_i);
            else if (advance) pc_q <= pc_plus4;

            if (capture_drop) drop_addr_q <= word_align(pc_q);

            if (redir || bubble) begin
                bus.valid_o <= 1'b0;
            end else if (deliver_mem) begin
                bus.Instr_o <= bus.imem_rdata_i;
                bus.PCp4_o  <= pc_plus4;
                bus.valid_o <= 1'b1;
            end else if (unpark) begin
                bus.Instr_o <= skid_data;
                bus.PCp4_o  <= skid_pcp4;
                bus.valid_o <= skid_valid;
            end
        end
    end

    if_skid_buf u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (park),
        .unload    (unpark),
        .clear     (redir),
        .load_data (bus.imem_rdata_i),
        .load_pcp4 (pc_plus4),
        .data      (skid_data),
        .pcp4      (skid_pcp4),
        .valid     (skid_valid)
    );

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC fetched first after reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, high releases it.
REQ-004 imem_req_o  output  1  instruction-memory request valid.
REQ-005 imem_addr_o  output  32  word-aligned fetch address; bits [1:0] always 00.
REQ-006 imem_ready_i  input  1  memory returns data this cycle for the outstanding request.
REQ-007 imem_rdata_i  input  32  instruction word; valid only with imem_ready_i.
REQ-008 stall_i  input  1  downstream IF/ID register cannot accept a new instruction (hazard hold).
REQ-009 redirect_i  input  1  branch, jump or jr taken; flush and refetch.
REQ-010 redirect_pc_i  input  32  redirect target; bits [1:0] ignored and treated as 00.
REQ-011 PCp4_o  output  32  PC+4 of the delivered instruction, feeding the IF/ID register PCp4_i.
REQ-012 Instr_o  output  32  delivered instruction word.
REQ-013 valid_o  output  1  PCp4_o and Instr_o hold a live instruction.

Function
REQ-014 The block SHALL keep a PC register pc_q and drive imem_addr_o = {pc_q[31:2],2'b00} whenever imem_req_o=1.
REQ-015 The block SHALL use a 4-state FSM: S_START (no request), S_REQ (request outstanding), S_HOLD (word parked because of stall), S_DROP (outstanding request to be discarded).
REQ-016 S_START SHALL last exactly one cycle after reset release and then go to S_REQ.
REQ-017 In S_REQ and S_DROP, imem_req_o SHALL be 1, and imem_addr_o SHALL stay stable until imem_ready_i=1; an issued request is never withdrawn.
REQ-018 In S_REQ with ready=1, stall=0 and redirect=0, the block SHALL, on the same edge, set Instr_o<=rdata, PCp4_o<=pc_q+4, valid_o<=1 and pc_q<=pc_q+4, and stay in S_REQ. This gives back-to-back fetch at one instruction per cycle when memory is zero-wait.
REQ-019 In S_REQ with ready=1 and stall=1, the block SHALL capture the word and its pc_q+4 into a one-entry skid buffer, advance pc_q and go to S_HOLD. Outputs stay unchanged.
REQ-020 In S_HOLD, imem_req_o SHALL be 0. When stall_i=0, the skid entry moves to the outputs with valid_o=1 and the FSM returns to S_REQ.
REQ-021 While stall_i=1 and redirect_i=0, PCp4_o, Instr_o and valid_o SHALL hold their values.
REQ-022 In S_REQ with ready=0 and stall=0, valid_o SHALL go to 0 (bubble).
REQ-023 redirect_i SHALL take priority over stall_i and over any response, in every state except S_START.
- On redirect: valid_o<=0, skid cleared, pc_q<={redirect_pc_i[31:2],2'b00}.
- If a request is outstanding and ready=0: go to S_DROP.
- Otherwise: go to S_REQ.
REQ-024 In S_DROP, the returned word SHALL be discarded when ready=1, and the FSM goes to S_REQ with the redirected pc_q. A second redirect while in S_DROP SHALL overwrite pc_q and stay in S_DROP.
REQ-025 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 gives 32'h0000_0000, with no flag.

Reset
REQ-026 While reset=0: pc_q=RESET_PC, state S_START, imem_req_o=0, valid_o=0, PCp4_o=0, Instr_o=0, skid empty.
REQ-027 Reset asserted mid-request SHALL abandon the request. Any ready pulse in the first cycle after release SHALL be ignored.

Structure
REQ-028 FSM state encodings and the NOP word 32'h0000_0000 SHALL live in the shared pipeline package, reused by the IF/ID and ID stages.
REQ-029 The skid buffer SHALL be a sub-module if_skid_buf (one entry: 32-bit data, 32-bit PCp4, valid, load/unload).

Verification
REQ-030 Reset release with zero-wait memory -> requests at 0x0, 0x4, 0x8 on consecutive cycles; PCp4_o = 0x4, 0x8, 0xC with valid_o=1.
REQ-031 Two-cycle ready latency on address 0x10 -> imem_addr_o held at 0x10 for both cycles; one bubble (valid_o=0); then PCp4_o=0x14.
REQ-032 stall_i=1 for 3 cycles while the word for 0x8 returns -> outputs frozen at PCp4_o=0x8; imem_req_o=0 during S_HOLD; on release PCp4_o=0xC, then the request for 0xC.
REQ-033 redirect_i with target 0x40, arriving while the request for 0x14 waits -> that word never appears on Instr_o; the next request is 0x40; the next valid PCp4_o=0x44.
REQ-034 Simultaneous stall_i and redirect_i (target 0x81, bits [1:0] ignored) -> valid_o=0; the next request is 0x80.
REQ-035 RESET_PC=32'hFFFF_FFFC -> first PCp4_o=0x0; second request to address 0x0.
